// File: rtl/out_fifo_arbiter.sv
// out_fifo_arbiter
//
// Shares the single write port of the FPGA-to-FT2232 output async FIFO
// between two byte-stream requesters. Ownership is per packet: a granted
// requester keeps the port until its last byte is accepted, so packets never
// interleave. Arbitration between simultaneous requests is round-robin.
//
// Optional feature macro: OUT_ARB_WATCHDOG_EN
//   When defined, a packet reaching MAX_PKT_LEN bytes without a last flag is
//   truncated: that byte is still written, the port returns to IDLE and
//   err_pkt_len_o pulses alongside that byte's write. When undefined there is
//   no length limit and err_pkt_len_o is tied low.
//
// Parameters:
//   MAX_PKT_LEN          maximum bytes per packet (2..255), watchdog only
//
// Ports:
//   clk_i                write-side clock (also the FIFO write clock)
//   reset_n_i            asynchronous active-low reset
//   req0_i/req1_i        requester has a valid byte
//   data0_i/data1_i      requester byte
//   last0_i/last1_i      byte is the final byte of its packet
//   grant0_o/grant1_o    requester currently owns the port
//   ack0_o/ack1_o        requester byte accepted this cycle (combinational)
//   wr_out_fifo_en_o     registered FIFO write enable
//   wr_out_fifo_data_o   registered FIFO write data
//   wr_out_fifo_full_i   FIFO full (already in the clk_i domain)
//   wr_out_fifo_afull_i  FIFO has exactly one free slot
//   err_pkt_len_o        one-cycle pulse when the watchdog truncates a packet

module out_fifo_arbiter #(
  parameter int unsigned MAX_PKT_LEN = 64
) (
  input  logic       clk_i,
  input  logic       reset_n_i,

  input  logic       req0_i,
  input  logic [7:0] data0_i,
  input  logic       last0_i,
  output logic       grant0_o,
  output logic       ack0_o,

  input  logic       req1_i,
  input  logic [7:0] data1_i,
  input  logic       last1_i,
  output logic       grant1_o,
  output logic       ack1_o,

  output logic       wr_out_fifo_en_o,
  output logic [7:0] wr_out_fifo_data_o,
  input  logic       wr_out_fifo_full_i,
  input  logic       wr_out_fifo_afull_i,

  output logic       err_pkt_len_o
);

  if ((MAX_PKT_LEN < 2) || (MAX_PKT_LEN > 255)) begin : g_max_pkt_len_range
    $error("out_fifo_arbiter: MAX_PKT_LEN must be in 2..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       last_owner;

  logic       room;
  logic       accept;
  logic       acc_last;
  logic [7:0] acc_data;
  logic       trunc;

  // A write issued last cycle into the final free slot makes the FIFO full
  // before the registered full flag can show it, so it blocks accept too.
  always_comb begin
    room = ~wr_out_fifo_full_i & ~(wr_out_fifo_en_o & wr_out_fifo_afull_i);
  end

  // ---------------------------------------------------------------------
  // State register and round-robin memory
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state      <= IDLE;
      last_owner <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (state_nxt == OWN0) last_owner <= 1'b0;
        if (state_nxt == OWN1) last_owner <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        // On a tie the requester that did not own the port last time wins.
        if (req0_i && (!req1_i || last_owner)) begin
          state_nxt = OWN0;
        end else if (req1_i) begin
          state_nxt = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (accept && (acc_last || trunc)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------
  always_comb begin
    grant0_o = 1'b0;
    grant1_o = 1'b0;
    ack0_o   = 1'b0;
    ack1_o   = 1'b0;
    accept   = 1'b0;
    acc_last = 1'b0;
    acc_data = data0_i;
    unique case (state)
      OWN0: begin
        grant0_o = 1'b1;
        ack0_o   = req0_i & room;
        accept   = req0_i & room;
        acc_last = last0_i;
        acc_data = data0_i;
      end
      OWN1: begin
        grant1_o = 1'b1;
        ack1_o   = req1_i & room;
        accept   = req1_i & room;
        acc_last = last1_i;
        acc_data = data1_i;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Registered FIFO write port; data holds between writes
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_out_fifo_en_o   <= 1'b0;
      wr_out_fifo_data_o <= '0;
    end else begin
      wr_out_fifo_en_o <= accept;
      if (accept) begin
        wr_out_fifo_data_o <= acc_data;
      end
    end
  end

`ifdef OUT_ARB_WATCHDOG_EN
  // Byte counter for the current owner. Holding it clear throughout IDLE
  // gives the same value on entry to OWNx as clearing it at the entry edge.
  localparam logic [7:0] CNT_LAST = 8'(MAX_PKT_LEN - 1);

  logic [7:0] byte_cnt;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      byte_cnt <= '0;
    end else if (state == IDLE) begin
      byte_cnt <= '0;
    end else if (accept) begin
      byte_cnt <= byte_cnt + 8'd1;
    end
  end

  // The accept that brings the counter up to MAX_PKT_LEN truncates the
  // packet unless that byte is already the last one.
  always_comb begin
    trunc = accept & ~acc_last & (byte_cnt == CNT_LAST);
  end

  // Registered so the pulse lines up with the truncating byte's write.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      err_pkt_len_o <= 1'b0;
    end else begin
      err_pkt_len_o <= trunc;
    end
  end
`else
  always_comb begin
    trunc = 1'b0;
  end

  assign err_pkt_len_o = 1'b0;
`endif

endmodule

// File: tb/tb_out_fifo_arbiter.sv
module tb_out_fifo_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req0, last0, req1, last1;
  logic [7:0] data0, data1;
  logic       grant0, ack0, grant1, ack1;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, afull;
  logic       err;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];   // expected FIFO write sequence
  logic [8:0] q0[$];      // {last, data} bytes queued at requester 0
  logic [8:0] q1[$];      // {last, data} bytes queued at requester 1

  always #5 clk = ~clk;

  out_fifo_arbiter #(.MAX_PKT_LEN(4)) dut (
    .clk_i               (clk),
    .reset_n_i           (reset_n),
    .req0_i              (req0),
    .data0_i             (data0),
    .last0_i             (last0),
    .grant0_o            (grant0),
    .ack0_o              (ack0),
    .req1_i              (req1),
    .data1_i             (data1),
    .last1_i             (last1),
    .grant1_o            (grant1),
    .ack1_o              (ack1),
    .wr_out_fifo_en_o    (wr_en),
    .wr_out_fifo_data_o  (wr_data),
    .wr_out_fifo_full_i  (full),
    .wr_out_fifo_afull_i (afull),
    .err_pkt_len_o       (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Requester models: present the queue head, pop it after an observed ack.
  initial begin
    logic a0, a1;
    req0 = 1'b0; last0 = 1'b0; data0 = '0;
    req1 = 1'b0; last1 = 1'b0; data1 = '0;
    forever begin
      @(negedge clk);
      a0 = ack0;
      a1 = ack1;
      @(posedge clk);
      #1;
      if (a0 && q0.size() != 0) void'(q0.pop_front());
      if (a1 && q1.size() != 0) void'(q1.pop_front());
      if (q0.size() != 0) begin
        req0 = 1'b1; last0 = q0[0][8]; data0 = q0[0][7:0];
      end else begin
        req0 = 1'b0; last0 = 1'b0;
      end
      if (q1.size() != 0) begin
        req1 = 1'b1; last1 = q1[0][8]; data1 = q1[0][7:0];
      end else begin
        req1 = 1'b0; last1 = 1'b0;
      end
    end
  end

  // FIFO-side monitor: every write must match the next expected byte and
  // must not follow a cycle in which the FIFO reported full.
  initial begin
    logic       full_prev;
    logic [7:0] e;
    full_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && wr_en === 1'b1) begin
        chk("write_while_full", full_prev, 1'b0);
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL fifo_write: got unexpected byte %0h, expected no write", wr_data);
        end else begin
          e = exp_q.pop_front();
          if (wr_data !== e) begin
            fails++;
            $display("FAIL fifo_write: got %0h expected %0h", wr_data, e);
          end
        end
      end
      full_prev = full;
    end
  end

  initial begin
    logic [5:0]  t1_g, t1_en;
    logic [8:0]  bp_ack, bp_en;
    logic [6:0]  ls_ack, ls_en;
    logic [12:0] rr_g0, rr_g1;
    logic [8:0]  wd_g, wd_err;
    int          guard;

    t1_g   = 6'b001110;
    t1_en  = 6'b011100;
    bp_ack = 9'b011100010;
    bp_en  = 9'b111000100;
    ls_ack = 7'b0110010;
    ls_en  = 7'b1100100;
    rr_g0  = 13'b0000110000110;
    rr_g1  = 13'b0110000110000;
`ifdef OUT_ARB_WATCHDOG_EN
    wd_g   = 9'b011011110;
    wd_err = 9'b000100000;
`else
    wd_g   = 9'b001111110;
    wd_err = 9'b000000000;
`endif

    reset_n = 1'b0;
    full    = 1'b0;
    afull   = 1'b0;

    // Reset values
    #3;
    chk("rst_grant0", grant0, 1'b0);
    chk("rst_grant1", grant1, 1'b0);
    chk("rst_ack0", ack0, 1'b0);
    chk("rst_ack1", ack1, 1'b0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_wr_data", wr_data, 8'h00);
    chk("rst_err", err, 1'b0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    smp();

    // Single 3-byte packet on requester 0
    q0.push_back({1'b0, 8'hA1}); q0.push_back({1'b0, 8'hA2}); q0.push_back({1'b1, 8'hA3});
    exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
    for (int c = 0; c < 6; c++) begin
      nxt(); smp();
      chk("single_grant0", grant0, t1_g[c]);
      chk("single_ack0", ack0, t1_g[c]);
      chk("single_wr_en", wr_en, t1_en[c]);
      chk("single_grant1", grant1, 1'b0);
    end

    // Backpressure: full for 3 cycles while the second byte waits
    q0.push_back({1'b0, 8'hD1}); q0.push_back({1'b0, 8'hD2});
    q0.push_back({1'b0, 8'hD3}); q0.push_back({1'b1, 8'hD4});
    exp_q.push_back(8'hD1); exp_q.push_back(8'hD2); exp_q.push_back(8'hD3); exp_q.push_back(8'hD4);
    for (int c = 0; c < 9; c++) begin
      nxt();
      full = (c >= 2 && c <= 4);
      smp();
      chk("bp_ack0", ack0, bp_ack[c]);
      chk("bp_wr_en", wr_en, bp_en[c]);
    end

    // Last slot: afull with a write pending, then full, then free
    q0.push_back({1'b0, 8'hE1}); q0.push_back({1'b0, 8'hE2}); q0.push_back({1'b1, 8'hE3});
    exp_q.push_back(8'hE1); exp_q.push_back(8'hE2); exp_q.push_back(8'hE3);
    for (int c = 0; c < 7; c++) begin
      nxt();
      afull = (c == 2);
      full  = (c == 3);
      smp();
      chk("ls_ack0", ack0, ls_ack[c]);
      chk("ls_wr_en", wr_en, ls_en[c]);
      chk("ls_grant0", grant0, (c >= 1 && c <= 5));
    end

    // Reset mid-packet after 2 of 5 bytes have been written
    q0.push_back({1'b0, 8'hF1}); q0.push_back({1'b0, 8'hF2}); q0.push_back({1'b0, 8'hF3});
    q0.push_back({1'b0, 8'hF4}); q0.push_back({1'b1, 8'hF5});
    exp_q.push_back(8'hF1); exp_q.push_back(8'hF2);
    for (int c = 0; c < 4; c++) begin
      nxt(); smp();
      chk("mid_ack0", ack0, (c >= 1));
    end
    #1 reset_n = 1'b0;
    q0.delete();
    #1;
    chk("mid_rst_grant0", grant0, 1'b0);
    chk("mid_rst_ack0", ack0, 1'b0);
    chk("mid_rst_wr_en", wr_en, 1'b0);
    chk("mid_rst_wr_data", wr_data, 8'h00);
    chk("mid_rst_err", err, 1'b0);
    nxt(); smp();
    chk("mid_rst_hold_wr_en", wr_en, 1'b0);
    chk("mid_rst_hold_grant0", grant0, 1'b0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    smp();

    // Lone request from requester 1 after reset is granted
    q1.push_back({1'b0, 8'h61}); q1.push_back({1'b1, 8'h62});
    exp_q.push_back(8'h61); exp_q.push_back(8'h62);
    for (int c = 0; c < 4; c++) begin
      nxt(); smp();
      chk("post_rst_grant1", grant1, (c == 1 || c == 2));
      chk("post_rst_ack1", ack1, (c == 1 || c == 2));
      chk("post_rst_grant0", grant0, 1'b0);
    end

    // Tie: both hold 2-byte packets; requester 0 wins first (last_owner = 1)
    q0.push_back({1'b0, 8'hB1}); q0.push_back({1'b1, 8'hB2});
    q0.push_back({1'b0, 8'hB3}); q0.push_back({1'b1, 8'hB4});
    q1.push_back({1'b0, 8'hC1}); q1.push_back({1'b1, 8'hC2});
    q1.push_back({1'b0, 8'hC3}); q1.push_back({1'b1, 8'hC4});
    exp_q.push_back(8'hB1); exp_q.push_back(8'hB2); exp_q.push_back(8'hC1); exp_q.push_back(8'hC2);
    exp_q.push_back(8'hB3); exp_q.push_back(8'hB4); exp_q.push_back(8'hC3); exp_q.push_back(8'hC4);
    for (int c = 0; c < 13; c++) begin
      nxt(); smp();
      chk("rr_grant0", grant0, rr_g0[c]);
      chk("rr_grant1", grant1, rr_g1[c]);
      chk("rr_ack0", ack0, rr_g0[c]);
      chk("rr_ack1", ack1, rr_g1[c]);
    end

    // 6-byte packet, last only on the final byte; with the watchdog it is
    // cut after 4 bytes and the rest re-arbitrates as a new packet
    q0.push_back({1'b0, 8'h71}); q0.push_back({1'b0, 8'h72}); q0.push_back({1'b0, 8'h73});
    q0.push_back({1'b0, 8'h74}); q0.push_back({1'b0, 8'h75}); q0.push_back({1'b1, 8'h76});
    exp_q.push_back(8'h71); exp_q.push_back(8'h72); exp_q.push_back(8'h73);
    exp_q.push_back(8'h74); exp_q.push_back(8'h75); exp_q.push_back(8'h76);
    for (int c = 0; c < 9; c++) begin
      nxt(); smp();
      chk("long_grant0", grant0, wd_g[c]);
      chk("long_err", err, wd_err[c]);
    end

    // Drain: every expected byte must have been written
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      smp();
      guard++;
    end
    chk("drain_remaining", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
